uart_tx_arbiter: RTL and testbench

Shares the single UART transmit engine among NUM_REQ independent byte producers, such as CPU store path, debug monitor and DMA.
- Arbitration is round-robin.
- Drives the engine's data byte and one-cycle transmit-enable pulse.
- Sequences each byte by tracking the engine's tx-status (1 = idle).
- Sits between the requesters and the sender's txdata/txen/txstatus pins, replacing direct TX register writes.

---
 rtl/uart_arb_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_rr_picker.sv | 40 ++++
 rtl/uart_tx_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and defaults for the UART transmit arbiter.
//   arbState_t   : arbiter FSM states (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE)
//   uartByte_t   : one transmitted byte
//   DEF_NUM_REQ, DEF_BUSY_TIMEOUT : default parameter values for the top
// ---------------------------------------------------------------------------
package uart_arb_pkg;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_BUSY_TIMEOUT = 4;

    typedef logic [7:0] uartByte_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arbState_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational rotating-priority encoder. Scans i_req starting at i_ptr,
// wrapping modulo NUM_REQ, and reports the first set bit.
// Ports:
//   i_req    [NUM_REQ] : request vector
//   i_ptr    [IDX_W]   : index with highest priority this cycle
//   o_found            : at least one request set
//   o_winner [IDX_W]   : index of the selected request (0 when none)
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_winner
);

    // Walk offsets from farthest to nearest so the nearest hit to i_ptr
    // is the last one written and therefore wins.
    always_comb begin
        int               w_pos;
        logic [IDX_W-1:0] w_idx;
        o_found  = 1'b0;
        o_winner = '0;
        w_pos    = 0;
        w_idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = (int'(i_ptr) + k) % NUM_REQ;
            w_idx = IDX_W'(w_pos);
            if (i_req[w_idx]) begin
                o_found  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmit engine among NUM_REQ byte producers using
// round-robin arbitration. Accepts one byte at a time, issues a one-cycle
// tx_en pulse and follows tx_status (1 = idle) until the frame completes.
// If the engine never reports busy within BUSY_TIMEOUT cycles the byte is
// dropped and o_err pulses.
// Optional feature (macro UART_ARB_LOCK_EN): adds i_req_last so a requester
// can hold the engine for a multi-byte packet.
// Ports:
//   i_clk, i_rst              : clock, asynchronous active-high reset
//   i_req_valid [NUM_REQ]     : per-requester byte valid
//   i_req_data  [8*NUM_REQ]   : requester i byte in bits [8i+7:8i]
//   i_req_last  [NUM_REQ]     : (UART_ARB_LOCK_EN only) last byte of packet
//   o_req_ready [NUM_REQ]     : one-hot accept, byte taken on valid&ready
//   o_tx_data   [8]           : byte to sender, stable until next accept
//   o_tx_en                   : one-cycle start pulse to sender
//   i_tx_status               : sender status, 1 = idle
//   o_grant_id  [IDX_W]       : requester currently owning the engine
//   o_busy                    : high from accept until engine idle again
//   o_err                     : one-cycle pulse on busy timeout
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int IDX_W        = $clog2(NUM_REQ),
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [8*NUM_REQ-1:0] i_req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]   i_req_last,
`endif
    output logic [NUM_REQ-1:0]   o_req_ready,
    output uartByte_t            o_tx_data,
    output logic                 o_tx_en,
    input  logic                 i_tx_status,
    output logic [IDX_W-1:0]     o_grant_id,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int               CNT_W    = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    arbState_t          r_state;
    arbState_t          w_nextState;
    logic [IDX_W-1:0]   r_rrPtr;
    uartByte_t          r_txData;
    logic [IDX_W-1:0]   r_grantId;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;

    logic [NUM_REQ-1:0] w_pickReq;
    logic               w_found;
    logic [IDX_W-1:0]   w_winner;
    logic               w_accept;
    logic               w_timeout;
    logic               w_done;
    logic [IDX_W-1:0]   w_nextPtr;
    uartByte_t          w_winData;

`ifdef UART_ARB_LOCK_EN
    logic               r_lock;

    // While a packet is open only its owner may compete.
    assign w_pickReq = r_lock ? (i_req_valid & (NUM_REQ'(1) << r_grantId))
                              : i_req_valid;
`else
    assign w_pickReq = i_req_valid;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req    (w_pickReq),
        .i_ptr    (r_rrPtr),
        .o_found  (w_found),
        .o_winner (w_winner)
    );

    assign w_winData = i_req_data[{w_winner, 3'b000} +: 8];
    assign w_nextPtr = (r_grantId == IDX_W'(NUM_REQ - 1)) ? '0 : r_grantId + 1'b1;

    // Next-state and Moore/Mealy outputs. Ready is only ever raised in
    // IDLE with the engine idle, which keeps at most one byte in flight.
    always_comb begin
        w_nextState = r_state;
        o_req_ready = '0;
        o_tx_en     = 1'b0;
        o_err       = 1'b0;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_tx_status && w_found) begin
                    w_accept              = 1'b1;
                    o_req_ready[w_winner] = 1'b1;
                    w_nextState           = LAUNCH;
                end
            end
            LAUNCH: begin
                o_tx_en     = 1'b1;
                w_nextState = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!i_tx_status) begin
                    w_nextState = WAIT_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout   = 1'b1;
                    o_err       = 1'b1;
                    w_nextState = IDLE;
                end
            end
            WAIT_DONE: begin
                if (i_tx_status) begin
                    w_done      = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State, captured byte/grant, busy flag, timeout counter and the
    // round-robin pointer, which only moves once a byte is finished.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_rrPtr   <= '0;
            r_txData  <= '0;
            r_grantId <= '0;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
`ifdef UART_ARB_LOCK_EN
            r_lock    <= 1'b0;
`endif
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_txData  <= w_winData;
                r_grantId <= w_winner;
                r_busy    <= 1'b1;
`ifdef UART_ARB_LOCK_EN
                r_lock    <= !i_req_last[w_winner];
`endif
            end
            if (r_state == LAUNCH) begin
                r_cnt <= '0;
            end else if (r_state == WAIT_BUSY && i_tx_status && !w_timeout) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_busy  <= 1'b0;
                r_rrPtr <= w_nextPtr;
`ifdef UART_ARB_LOCK_EN
                r_lock  <= 1'b0;
`endif
            end
            if (w_done) begin
                r_busy <= 1'b0;
`ifdef UART_ARB_LOCK_EN
                if (!r_lock) begin
                    r_rrPtr <= w_nextPtr;
                end
`else
                r_rrPtr <= w_nextPtr;
`endif
            end
        end
    end

    assign o_tx_data  = r_txData;
    assign o_grant_id = r_grantId;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (default build, UART_ARB_LOCK_EN
// undefined). The bench plays both the requesters (per-requester byte
// queues) and the UART sender (tx_status timeline chosen per byte), and
// predicts every cycle from a transaction-level model: who wins, when the
// start pulse, error pulse and idle return happen.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 4;
    localparam int QD = 256;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   reqValid;
    logic [8*N-1:0] reqData;
    logic [N-1:0]   reqReady;
    logic [7:0]     txData;
    logic           txEn;
    logic           txStatus;
    logic [IW-1:0]  grantId;
    logic           busy;
    logic           err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .IDX_W        (IW),
        .BUSY_TIMEOUT (TO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (reqValid),
        .i_req_data  (reqData),
        .o_req_ready (reqReady),
        .o_tx_data   (txData),
        .o_tx_en     (txEn),
        .i_tx_status (txStatus),
        .o_grant_id  (grantId),
        .o_busy      (busy),
        .o_err       (err)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Requester byte queues.
    logic [7:0] qMem [N][QD];
    int         qHead [N];
    int         qTail [N];

    // Transaction-level model of the arbiter and sender.
    int         mPtr;
    int         freeAt;
    int         acceptAt;
    int         tEnAt;
    int         errAt;
    int         dropStart;
    int         dropEnd;
    logic [7:0] expData;
    int         expGrant;
    bit         forceTimeout;
    bit         randomTimeout;
    bit         forceBusy;
    bit         gateRandom;
    logic [7:0] dutSeen [$];
    int         lastDutGrant;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic modelReset();
        mPtr      = 0;
        freeAt    = cyc;
        acceptAt  = -100;
        tEnAt     = -1;
        errAt     = -1;
        dropStart = -1;
        dropEnd   = -1;
        expData   = 8'h00;
        expGrant  = 0;
        for (int i = 0; i < N; i++) begin
            qHead[i] = 0;
            qTail[i] = 0;
        end
    endtask

    task automatic pushByte(input int r, input logic [7:0] b);
        if (qTail[r] < QD) begin
            qMem[r][qTail[r]] = b;
            qTail[r]++;
        end
    endtask

    function automatic bit queuesEmpty();
        for (int i = 0; i < N; i++) if (qTail[i] > qHead[i]) return 1'b0;
        return 1'b1;
    endfunction

    // One bus cycle: drive at negedge, compare just after, then advance
    // the model if a byte is expected to be accepted this cycle.
    task automatic applyStimulus();
        logic [N-1:0] v;
        logic [N-1:0] expReady;
        int           win;
        int           d;
        int           f;
        @(negedge clk);
        cyc++;
        txStatus = !(forceBusy || (cyc >= dropStart && cyc < dropEnd));
        for (int i = 0; i < N; i++) begin
            v[i] = (qTail[i] > qHead[i]) && (!gateRandom || $urandom_range(0, 3) != 0);
            reqData[8*i +: 8] = v[i] ? qMem[i][qHead[i]] : 8'($urandom);
        end
        reqValid = v;
        #1;
        expReady = '0;
        win      = -1;
        if (cyc >= freeAt && txStatus && v != '0) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && v[(mPtr + k) % N]) win = (mPtr + k) % N;
            end
            expReady[win] = 1'b1;
        end
        checkOutput(expReady);
        if (win >= 0) begin
            expData  = qMem[win][qHead[win]];
            qHead[win]++;
            expGrant = win;
            acceptAt = cyc;
            tEnAt    = cyc + 1;
            mPtr     = (win + 1) % N;
            if (forceTimeout || (randomTimeout && $urandom_range(0, 7) == 0)) begin
                errAt     = tEnAt + TO;
                freeAt    = errAt + 1;
                dropStart = -1;
                dropEnd   = -1;
            end else begin
                d         = $urandom_range(1, 3);
                f         = $urandom_range(2, 5);
                errAt     = -1;
                dropStart = tEnAt + d;
                dropEnd   = dropStart + f;
                freeAt    = dropEnd + 1;
            end
        end
    endtask

    task automatic checkOutput(input logic [N-1:0] expReady);
        checkVal("req_ready", 32'(reqReady), 32'(expReady));
        checkVal("tx_en", 32'(txEn), 32'(cyc == tEnAt));
        checkVal("err", 32'(err), 32'(cyc == errAt));
        checkVal("busy", 32'(busy), 32'(cyc > acceptAt && cyc < freeAt));
        checkVal("tx_data", 32'(txData), 32'(expData));
        checkVal("grant_id", 32'(grantId), 32'(expGrant));
        if (txEn === 1'b1) begin
            dutSeen.push_back(txData);
            lastDutGrant = int'(grantId);
        end
    endtask

    task automatic runUntilIdle(input int bound);
        int n = 0;
        while ((!queuesEmpty() || cyc < freeAt) && n < bound) begin
            applyStimulus();
            n++;
        end
        if (n >= bound) checkVal("drain_bound", 32'd1, 32'd0);
    endtask

    task automatic doReset();
        rst      = 1'b1;
        reqValid = '0;
        txStatus = 1'b1;
        #1;
        checkVal("rst_tx_en", 32'(txEn), 32'd0);
        checkVal("rst_busy", 32'(busy), 32'd0);
        checkVal("rst_grant", 32'(grantId), 32'd0);
        checkVal("rst_ready", 32'(reqReady), 32'd0);
        checkVal("rst_err", 32'(err), 32'd0);
        checkVal("rst_tx_data", 32'(txData), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        reqValid      = '0;
        reqData       = '0;
        txStatus      = 1'b1;
        forceTimeout  = 1'b0;
        randomTimeout = 1'b0;
        forceBusy     = 1'b0;
        gateRandom    = 1'b0;
        lastDutGrant  = -1;
        modelReset();
        @(negedge clk);
        doReset();

        // Single request from requester 0.
        pushByte(0, 8'h41);
        runUntilIdle(50);
        checkVal("single_byte", 32'(dutSeen.size() > 0 ? dutSeen[0] : 8'h00), 32'h41);

        // Contention from a fresh pointer: all four requesters at once.
        doReset();
        dutSeen.delete();
        for (int i = 0; i < N; i++) pushByte(i, 8'(8'h10 + i));
        runUntilIdle(200);
        checkVal("contend_count", 32'(dutSeen.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < dutSeen.size()) checkVal("contend_order", 32'(dutSeen[i]), 32'(8'h10 + i));
        end

        // Wrap: after requester 3 was served, 0 beats 3.
        pushByte(3, 8'hA3);
        pushByte(0, 8'hA0);
        applyStimulus();
        applyStimulus();
        checkVal("wrap_grant", 32'(lastDutGrant), 32'd0);
        runUntilIdle(100);

        // Engine busy when a request appears.
        forceBusy = 1'b1;
        pushByte(1, 8'h5A);
        for (int i = 0; i < 5; i++) applyStimulus();
        forceBusy = 1'b0;
        runUntilIdle(50);
        checkVal("busy_start_grant", 32'(lastDutGrant), 32'd1);

        // Sender never starts: timeout, then the next requester is served.
        forceTimeout = 1'b1;
        pushByte(2, 8'hE2);
        applyStimulus();
        forceTimeout = 1'b0;
        pushByte(3, 8'hE3);
        runUntilIdle(100);
        checkVal("after_timeout_grant", 32'(lastDutGrant), 32'd3);

        // Randomised traffic with dropped valids and occasional timeouts.
        gateRandom    = 1'b1;
        randomTimeout = 1'b1;
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < N; r++) begin
                if ($urandom_range(0, 9) == 0) pushByte(r, 8'($urandom));
            end
            applyStimulus();
        end
        gateRandom    = 1'b0;
        randomTimeout = 1'b0;
        runUntilIdle(600);

        // Reset while the frame is on the wire.
        pushByte(2, 8'hC2);
        n = 0;
        while (!(dropStart > 0 && cyc == dropStart + 1) && n < 40) begin
            applyStimulus();
            n++;
        end
        if (n >= 40) checkVal("wait_done_bound", 32'd1, 32'd0);
        doReset();
        pushByte(1, 8'h77);
        runUntilIdle(50);
        checkVal("post_reset_grant", 32'(lastDutGrant), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
